// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, status codes, memory-stage state and op types.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [1:0] {IDLE, XFER, DONE} mem_state_e;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} mem_op_e;

    function automatic mem_op_e icode_op(input logic [3:0] icode);
        case (icode)
            ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL: return OP_WRITE;
            ICODE_MRMOVQ, ICODE_RET, ICODE_POPQ:   return OP_READ;
            ICODE_HALT, ICODE_NOP, ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_OPQ, ICODE_JXX:
                return OP_NONE;
            default: return OP_NONE;
        endcase
    endfunction

    // Status for instructions that never touch memory.
    function automatic logic [1:0] icode_stat(input logic [3:0] icode);
        if (icode == ICODE_HALT) return STAT_HLT;
        if (icode > ICODE_POPQ) return STAT_INS;
        return STAT_AOK;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory stage handshake and result bus.
interface mem_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        out_valid;
    logic [63:0] valM;
    logic [1:0]  stat;

    modport master (
        output in_valid, icode, valE, valA, valP,
        input  in_ready, out_valid, valM, stat
    );

    modport slave (
        input  in_valid, icode, valE, valA, valP,
        output in_ready, out_valid, valM, stat
    );
endinterface

// File: rtl/mem_stage_data_mem.sv
// Byte-addressable data memory with LANES consecutive byte lanes, byte enables and async read.
module data_mem #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned AW        = 10,
    parameter int unsigned LANES     = 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LANES-1:0]     be,
    input  logic [AW-1:0]        addr,
    input  logic [8*LANES-1:0]   wdata,
    output logic [8*LANES-1:0]   rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we && be[i]) mem[addr + AW'(i)] <= wdata[8*i +: 8];
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(LANES); i++) rdata[8*i +: 8] = mem[addr + AW'(i)];
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: bounds check, byte-serial data memory access, valM/stat result.
// Define MEM_STAGE_WIDE_EN to access all 8 bytes in a single XFER cycle.
module mem_stage
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned AW        = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_stage_if.slave     bus,
    input  logic           dbg_we,
    input  logic [AW-1:0]  dbg_addr,
    input  logic [7:0]     dbg_data
);

`ifdef MEM_STAGE_WIDE_EN
    localparam int unsigned LANES = 8;
`else
    localparam int unsigned LANES = 1;
`endif

    mem_state_e  state_q, state_d;
    mem_op_e     op_q, op_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d, rdata_q, rdata_d, valM_q, valM_d;
    logic [1:0]  stat_q, stat_d;

    logic                mem_we;
    logic [LANES-1:0]    mem_be;
    logic [AW-1:0]       mem_addr;
    logic [8*LANES-1:0]  mem_wdata, mem_rdata;

    logic [63:0] req_addr;
    logic [64:0] req_end;
    logic        addr_err;
    mem_op_e     req_op;

    assign req_op   = icode_op(bus.icode);
    assign req_addr = (bus.icode == ICODE_RET || bus.icode == ICODE_POPQ) ? bus.valA : bus.valE;
    // 65-bit sum so an address near 2^64 cannot wrap back into range.
    assign req_end  = {1'b0, req_addr} + 65'd7;
    assign addr_err = req_end > 65'(MEM_BYTES - 1);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        valM_d    = valM_q;
        stat_d    = stat_q;
        mem_we    = 1'b0;
        mem_be    = '1;
        mem_addr  = addr_q;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = req_op;
                    cnt_d   = '0;
                    rdata_d = '0;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = (bus.icode == ICODE_CALL) ? bus.valP : bus.valA;
                    state_d = DONE;
                    valM_d  = '0;
                    if (req_op == OP_NONE) begin
                        stat_d = icode_stat(bus.icode);
                    end else if (addr_err) begin
                        stat_d = STAT_ADR;
                    end else begin
                        state_d = XFER;
                    end
                end else if (dbg_we) begin
                    mem_we         = 1'b1;
                    mem_be         = LANES'(1);
                    mem_addr       = dbg_addr;
                    mem_wdata[7:0] = dbg_data;
                end
            end
            XFER: begin
`ifdef MEM_STAGE_WIDE_EN
                mem_we    = (op_q == OP_WRITE);
                mem_wdata = wdata_q;
                if (op_q == OP_READ) rdata_d = mem_rdata;
                state_d   = DONE;
`else
                mem_we    = (op_q == OP_WRITE);
                mem_addr  = addr_q + AW'(cnt_q);
                mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
                if (op_q == OP_READ) rdata_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = DONE;
`endif
                if (state_d == DONE) begin
                    valM_d = rdata_d;
                    stat_d = STAT_AOK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valM_q  <= '0;
            stat_q  <= STAT_AOK;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valM_q  <= valM_d;
            stat_q  <= stat_d;
        end
    end

    // Reset must also suppress the byte that would land on the reset edge.
    data_mem #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW),
        .LANES     (LANES)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we && rst_n),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.valM      = valM_q;
    assign bus.stat      = stat_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-array reference model.
module tb_mem_stage;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned AW        = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [7:0]    dbg_data = '0;

    mem_stage_if bus();

    mem_stage #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    logic [7:0] ref_mem [MEM_BYTES];
    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dbg_write(input int unsigned a, input logic [7:0] d);
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = AW'(a); dbg_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    // Reference: what a Y86 memory stage must produce for one instruction.
    task automatic model(input logic [3:0] ic, input logic [63:0] e, a, p,
                         output logic [63:0] exp_valM, output logic [1:0] exp_stat,
                         output int exp_lat);
        logic [63:0] addr;
        logic [63:0] data;
        bit rd, wr;
        rd = (ic == 4'h5 || ic == 4'h9 || ic == 4'hB);
        wr = (ic == 4'h4 || ic == 4'hA || ic == 4'h8);
        addr = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data = (ic == 4'h8) ? p : a;
        exp_valM = 64'd0;
        exp_lat  = 1;
        if (!rd && !wr) begin
            exp_stat = (ic == 4'h0) ? 2'd1 : (ic > 4'hB) ? 2'd3 : 2'd0;
        end else if (addr > 64'(MEM_BYTES - 8)) begin
            exp_stat = 2'd2;
        end else begin
            exp_stat = 2'd0;
            exp_lat  = 9;
            for (int k = 0; k < 8; k++) begin
                if (wr) ref_mem[int'(addr) + k] = data[8*k +: 8];
                else    exp_valM[8*k +: 8] = ref_mem[int'(addr) + k];
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] ic, input logic [63:0] e, a, p);
        logic [63:0] exp_valM;
        logic [1:0]  exp_stat;
        int exp_lat, lat;
        model(ic, e, a, p, exp_valM, exp_stat, exp_lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".valM"}, bus.valM, exp_valM);
        check_eq({tag, ".stat"}, 64'(bus.stat), 64'(exp_stat));
        @(negedge clk);
        check_eq({tag, ".idle"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    function automatic logic [63:0] gen_addr();
        case ($urandom_range(0, 3))
            0: return 64'($urandom_range(0, MEM_BYTES - 8));
            1: return 64'($urandom_range(MEM_BYTES - 14, MEM_BYTES + 6));
            2: return {$urandom, $urandom};
            default: return 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        logic [3:0]  ic;
        logic [63:0] e, a;
        int busy_ready;
        int lat;

        bus.in_valid = 1'b0; bus.icode = '0; bus.valE = '0; bus.valA = '0; bus.valP = '0;
        repeat (3) @(negedge clk);
        check_eq("rst.ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst.ovalid", 64'(bus.out_valid), 64'd0);
        check_eq("rst.valM", bus.valM, 64'd0);
        check_eq("rst.stat", 64'(bus.stat), 64'd0);
        rst_n = 1'b1;

        // Fill every byte so later reads never see uninitialised storage.
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            @(negedge clk);
            dbg_we = 1'b1; dbg_addr = AW'(i); dbg_data = 8'($urandom);
            ref_mem[i] = dbg_data;
        end
        @(negedge clk);
        dbg_we = 1'b0;

        for (int i = 0; i < 8; i++) dbg_write(32'h100 + i, 8'(i + 1));
        run_op("t1", 4'h5, 64'h100, 64'd0, 64'd0);
        check_eq("t1.const", bus.valM, 64'h0807060504030201);

        run_op("t2w", 4'h4, 64'h200, 64'hDEADBEEFCAFEF00D, 64'd0);
        run_op("t2r", 4'h5, 64'h200, 64'd0, 64'd0);
        check_eq("t2.const", bus.valM, 64'hDEADBEEFCAFEF00D);

        run_op("t3a", 4'h5, 64'(MEM_BYTES - 4), 64'd0, 64'd0);
        run_op("t3b", 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
        run_op("t3c", 4'h4, 64'(MEM_BYTES - 7), 64'h1111_2222_3333_4444, 64'd0);
        run_op("t3d", 4'h5, 64'(MEM_BYTES - 8), 64'd0, 64'd0);
        run_op("t4a", 4'h6, 64'h123, 64'h456, 64'd0);
        run_op("t4b", 4'h0, 64'd0, 64'd0, 64'd0);
        run_op("t4c", 4'hE, 64'd0, 64'd0, 64'd0);

        // Reset sampled at the edge where cnt=3: bytes 0..2 written, byte 3 not.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.icode = 4'h8; bus.valE = 64'h300; bus.valP = 64'h42;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t5.ready", 64'(bus.in_ready), 64'd1);
        check_eq("t5.ovalid", 64'(bus.out_valid), 64'd0);
        check_eq("t5.valM", bus.valM, 64'd0);
        ref_mem[32'h300] = 8'h42; ref_mem[32'h301] = 8'h00; ref_mem[32'h302] = 8'h00;
        run_op("t5r", 4'h5, 64'h300, 64'd0, 64'd0);

        // in_valid and dbg_we held during XFER must be ignored.
        run_op("t6w", 4'h4, 64'h208, 64'h0123_4567_89AB_CDEF, 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.icode = 4'h5; bus.valE = 64'h208;
        @(negedge clk);
        bus.icode = 4'h0; bus.valE = 64'h100;
        dbg_we = 1'b1; dbg_addr = AW'(32'h100); dbg_data = 8'hFF;
        busy_ready = 0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ready++;
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0; dbg_we = 1'b0;
        check_eq("t6.busyready", 64'(busy_ready), 64'd0);
        check_eq("t6.lat", 64'(lat), 64'd9);
        check_eq("t6.valM", bus.valM, 64'h0123_4567_89AB_CDEF);
        check_eq("t6.stat", 64'(bus.stat), 64'd0);
        @(negedge clk);
        check_eq("t6.idle", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        run_op("t6r", 4'h5, 64'h100, 64'd0, 64'd0);

        for (int n = 0; n < 200; n++) begin
            ic = 4'($urandom_range(0, 15));
            e  = gen_addr();
            a  = (ic == 4'h9 || ic == 4'hB) ? gen_addr() : {$urandom, $urandom};
            run_op("rnd", ic, e, a, {$urandom, $urandom});
        end

        for (int q = 0; q < int'(MEM_BYTES / 8); q++) run_op("final", 4'h5, 64'(q * 8), 64'd0, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
